// File: rtl/roulette_pkg.sv
// Shared types and constants for the roulette spin sequencer.
package roulette_pkg;

  typedef enum logic [1:0] {IDLE, SPIN, SLOW, HOLD} spin_state_t;

  localparam int NUM_LEDS_DEFAULT = 16;
  localparam int POS_W = $clog2(NUM_LEDS_DEFAULT);

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1: taps on bits 15, 13, 12, 10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/roulette_spin_ctrl_if.sv
// Button input and display-side outputs of the spin sequencer.
interface roulette_spin_ctrl_if import roulette_pkg::*; #(
  parameter int NUM_LEDS = NUM_LEDS_DEFAULT
);
  localparam int PW = $clog2(NUM_LEDS);

  logic                button;
  logic [NUM_LEDS-1:0] external_leds;
  logic [PW-1:0]       result;
  logic                result_valid;
  logic                busy;
  spin_state_t         state_o;

  modport master (input button, output external_leds, result, result_valid, busy, state_o);
  modport slave  (output button, input external_leds, result, result_valid, busy, state_o);

endinterface

// File: rtl/button_debounce.sv
// Two-flop synchronizer, stable-level debouncer and rising-edge press pulse.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1, sync2, level;
  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      press <= 1'b0;
      // Any sample agreeing with the accepted level restarts the run.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        press <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/roulette_spin_ctrl.sv
// Roulette ball chase: debounced press starts a spin that decelerates and
// stops on a pseudo-random pocket, then holds the result before re-arming.
module roulette_spin_ctrl import roulette_pkg::*; #(
  parameter int NUM_LEDS        = NUM_LEDS_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BASE_PERIOD     = 2_500_000,
  parameter int PERIOD_INC      = 1_500_000,
  parameter int MAX_PERIOD      = 25_000_000,
  parameter int MIN_STEPS       = 48,
  parameter int SLOW_STEPS      = 12,
  parameter int HOLD_CYCLES     = 200_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  roulette_spin_ctrl_if.master  bus
);
  localparam int PW     = $clog2(NUM_LEDS);
  localparam int STEP_W = $clog2(MIN_STEPS + 64);

  spin_state_t       state, state_next;
  logic              press;
  logic [15:0]       lfsr;
  logic [PW-1:0]     pos;
  logic [PW-1:0]     result;
  logic              result_valid;
  logic              have_result;
  logic [31:0]       timer, period, period_sat;
  logic [STEP_W-1:0] steps_left, steps_dec;
  logic              step;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .button (bus.button),
    .press  (press)
  );

  assign step      = (timer == period - 32'd1);
  assign steps_dec = steps_left - STEP_W'(1);
  // Compare against the headroom first so the add can never wrap.
  assign period_sat = (period > 32'(MAX_PERIOD - PERIOD_INC)) ? 32'(MAX_PERIOD)
                                                              : period + 32'(PERIOD_INC);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: defaults first so no path through this block can infer a latch.
  always_comb begin
    state_next        = state;
    bus.busy          = (state != IDLE);
    bus.state_o       = state;
    bus.external_leds = '0;
    if (state != IDLE || have_result) bus.external_leds = NUM_LEDS'(1) << pos;
    unique case (state)
      IDLE: if (press) state_next = SPIN;
      SPIN: if (step) begin
        if (steps_dec == '0)                           state_next = HOLD;
        else if (steps_dec <= STEP_W'(SLOW_STEPS))     state_next = SLOW;
      end
      SLOW: if (step && steps_dec == '0)               state_next = HOLD;
      HOLD: if (timer == 32'(HOLD_CYCLES - 1))         state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr         <= LFSR_SEED;
      pos          <= '0;
      timer        <= '0;
      period       <= '0;
      steps_left   <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      have_result  <= 1'b0;
    end else begin
      lfsr         <= lfsr_next(lfsr);
      result_valid <= 1'b0;
      unique case (state)
        IDLE: if (press) begin
          steps_left <= STEP_W'(MIN_STEPS) + STEP_W'(lfsr[5:0]);
          period     <= 32'(BASE_PERIOD);
          timer      <= '0;
        end
        SPIN, SLOW: if (step) begin
          timer      <= '0;
          pos        <= pos + PW'(1);
          steps_left <= steps_dec;
          // The step entering the slow window already lengthens the next interval.
          if (steps_dec <= STEP_W'(SLOW_STEPS)) period <= period_sat;
          if (steps_dec == '0) begin
            result       <= pos + PW'(1);
            result_valid <= 1'b1;
            have_result  <= 1'b1;
          end
        end else begin
          timer <= timer + 32'd1;
        end
        HOLD: timer <= timer + 32'd1;
        default: ;
      endcase
    end
  end

  assign bus.result       = result;
  assign bus.result_valid = result_valid;

endmodule

// File: tb/tb_roulette_spin_ctrl.sv
// Directed bench for roulette_spin_ctrl with an LFSR mirror and a result scoreboard.
module tb_roulette_spin_ctrl;
  import roulette_pkg::*;

  localparam int MIN_STEPS   = 16;
  localparam int SLOW_STEPS  = 4;
  localparam int HOLD_CYCLES = 10;
  localparam int BASE        = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  roulette_spin_ctrl_if #(.NUM_LEDS(16)) bus_a ();
  roulette_spin_ctrl_if #(.NUM_LEDS(16)) bus_b ();

  roulette_spin_ctrl #(
    .NUM_LEDS(16), .DEBOUNCE_CYCLES(3), .BASE_PERIOD(4), .PERIOD_INC(2),
    .MAX_PERIOD(20), .MIN_STEPS(16), .SLOW_STEPS(4), .HOLD_CYCLES(10)
  ) dut_a (.clk(clk), .rst(rst), .bus(bus_a.master));

  roulette_spin_ctrl #(
    .NUM_LEDS(16), .DEBOUNCE_CYCLES(3), .BASE_PERIOD(4), .PERIOD_INC(8),
    .MAX_PERIOD(20), .MIN_STEPS(16), .SLOW_STEPS(4), .HOLD_CYCLES(10)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b.master));

  // Observation mux: sel picks which instance the checks look at.
  logic             sel;
  logic [15:0]      o_leds;
  logic [POS_W-1:0] o_result;
  logic             o_rv, o_busy;
  spin_state_t      o_state;

  always_comb begin
    if (sel) begin
      o_leds = bus_b.external_leds; o_result = bus_b.result;
      o_rv = bus_b.result_valid;    o_busy = bus_b.busy; o_state = bus_b.state_o;
    end else begin
      o_leds = bus_a.external_leds; o_result = bus_a.result;
      o_rv = bus_a.result_valid;    o_busy = bus_a.busy; o_state = bus_a.state_o;
    end
  end

  // LFSR mirror written straight from the polynomial.
  logic [15:0] m_lfsr, m_lfsr_prev;
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    m_lfsr_prev <= m_lfsr;
  end

  int tests = 0;
  int fails = 0;
  int btn_a = 0;
  int btn_b = 0;
  logic [POS_W-1:0] sb [$];

  function automatic logic [15:0] onehot(logic [POS_W-1:0] p);
    logic [15:0] one;
    one = 16'd1;
    return one << p;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and apply any pending button hold.
  task automatic cycle();
    @(negedge clk);
    bus_a.button = (btn_a > 0);
    if (btn_a > 0) btn_a--;
    bus_b.button = (btn_b > 0);
    if (btn_b > 0) btn_b--;
  endtask

  task automatic wait_spin();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      cycle();
      if (o_state == SPIN) found = 1'b1;
    end
    check("spin_start", 64'(o_state), 64'(SPIN));
  endtask

  task automatic idle_quiet(string tag, int n);
    for (int i = 0; i < n; i++) begin
      cycle();
      check(tag, 64'({o_busy, o_rv, o_state}), 64'(0));
    end
  endtask

  // Follows one spin from its first SPIN cycle until it is back in IDLE.
  task automatic run_spin(input logic [POS_W-1:0] start_pos, input int s0, input int s1,
                          input int s2, input int s3, input bit inject,
                          output logic [POS_W-1:0] end_pos);
    int exp_slow [4];
    int steps, cyc, last, nsteps, rv_cnt, hold_cnt, idx;
    bit wrapped, inj_spin, inj_slow, inj_hold;
    logic [POS_W-1:0] mpos, exp_res;
    exp_slow = '{s0, s1, s2, s3};
    steps    = MIN_STEPS + int'(m_lfsr_prev[5:0]);
    exp_res  = POS_W'(int'(start_pos) + steps);
    sb.push_back(exp_res);
    check("spin_busy", 64'(o_busy), 64'(1));
    check("spin_leds_start", 64'(o_leds), 64'(onehot(start_pos)));
    mpos = start_pos; cyc = 0; last = 0; nsteps = 0; rv_cnt = 0; hold_cnt = 0;
    wrapped = 0; inj_spin = 0; inj_slow = 0; inj_hold = 0;
    for (int g = 0; g < 3000; g++) begin
      cycle();
      cyc++;
      if (inject) begin
        if (!inj_spin && o_state == SPIN && cyc == 20) begin btn_a = 8; inj_spin = 1; end
        if (!inj_slow && o_state == SLOW)              begin btn_a = 8; inj_slow = 1; end
        if (!inj_hold && o_state == HOLD)              begin btn_a = 8; inj_hold = 1; end
      end
      if (o_leds !== onehot(mpos)) begin
        nsteps++;
        if (mpos == POS_W'(15)) wrapped = 1;
        mpos = mpos + POS_W'(1);
        check("step_pos", 64'(o_leds), 64'(onehot(mpos)));
        if (nsteps <= steps - SLOW_STEPS) begin
          check("spin_interval", 64'(cyc - last), 64'(BASE));
        end else begin
          idx = nsteps - (steps - SLOW_STEPS) - 1;
          if (idx < 4) check("slow_interval", 64'(cyc - last), 64'(exp_slow[idx]));
          else         check("extra_step", 64'(nsteps), 64'(steps));
        end
        last = cyc;
      end
      if (o_rv) begin
        rv_cnt++;
        if (sb.size() > 0) check("result", 64'(o_result), 64'(sb.pop_front()));
        else               check("result_valid_extra", 64'(o_rv), 64'(0));
      end
      if (o_state == HOLD) hold_cnt++;
      if (o_state == IDLE) break;
    end
    check("spin_done", 64'(o_state), 64'(IDLE));
    check("step_count", 64'(nsteps), 64'(steps));
    check("result_valid_pulses", 64'(rv_cnt), 64'(1));
    check("hold_cycles", 64'(hold_cnt), 64'(HOLD_CYCLES));
    check("wrap_15_0", 64'(wrapped), 64'(1));
    check("idle_busy", 64'(o_busy), 64'(0));
    check("idle_leds", 64'(o_leds), 64'(onehot(mpos)));
    check("result_model_pos", 64'(o_result), 64'(mpos));
    end_pos = mpos;
  endtask

  initial begin
    logic [POS_W-1:0] p;
    bit found;
    sel = 1'b0;
    bus_a.button = 1'b0;
    bus_b.button = 1'b0;

    // Reset and quiet idle.
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      check("reset_idle", 64'({o_leds, o_result, o_rv, o_busy, o_state}), 64'(0));
    end

    // A two-cycle glitch never reaches the debounced level.
    btn_a = 2;
    idle_quiet("glitch_busy", 20);

    // Held button starts a full spin.
    btn_a = 10;
    wait_spin();
    run_spin(POS_W'(0), 6, 8, 10, 12, 1'b0, p);
    idle_quiet("after_spin1", 20);

    // Presses during SPIN, SLOW and HOLD are dropped.
    btn_a = 10;
    wait_spin();
    run_spin(p, 6, 8, 10, 12, 1'b1, p);
    idle_quiet("no_restart", 20);

    // A press in IDLE starts from the previous result.
    btn_a = 10;
    wait_spin();
    run_spin(p, 6, 8, 10, 12, 1'b0, p);
    idle_quiet("after_spin3", 20);

    // Saturating deceleration on the PERIOD_INC=8 instance.
    sel = 1'b1;
    btn_b = 10;
    wait_spin();
    run_spin(POS_W'(0), 12, 20, 20, 20, 1'b0, p);
    idle_quiet("after_sat", 20);

    // Reset in the middle of a spin abandons it.
    sel = 1'b0;
    btn_a = 10;
    wait_spin();
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      cycle();
      if (o_state == SLOW) found = 1'b1;
    end
    check("reach_slow", 64'(o_state), 64'(SLOW));
    rst = 1'b1;
    cycle();
    check("mid_reset", 64'({o_leds, o_result, o_rv, o_busy, o_state}), 64'(0));
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      check("post_reset", 64'({o_leds, o_rv, o_busy, o_state}), 64'(0));
    end
    check("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
